keccak_perm_ctrl: RTL and testbench

- Sequences the Keccak-f step datapath over a slice-organised state memory: theta column-parity, rho, pi, chi and iota.
- Walks every slice address through the selected step for each step of each round.
- Issues read and write strobes, with writes following reads by a fixed pipeline latency.
- Exposes step select and round index to the datapath (iota constant lookup) and a start/busy/done handshake to the host.

---
 rtl/keccak_perm_ctrl_if.sv | 27 ++
 rtl/keccak_perm_ctrl.sv | 148 ++++++++++++++
 tb/tb_keccak_perm_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/keccak_perm_ctrl_if.sv
// Host/datapath-facing bundle of the Keccak permutation sequencer:
// start/stall in, handshake status, step/round select and slice strobes out.
interface keccak_perm_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int RND_W  = 5
);
    logic              start;
    logic              stall;
    logic              busy;
    logic              done;
    logic [RND_W-1:0]  round_idx;
    logic [2:0]        step_sel;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    modport master (
        output start, stall,
        input  busy, done, round_idx, step_sel, rd_en, rd_addr, wr_en, wr_addr
    );

    modport slave (
        input  start, stall,
        output busy, done, round_idx, step_sel, rd_en, rd_addr, wr_en, wr_addr
    );
endinterface

// File: rtl/keccak_perm_ctrl.sv
// Keccak-f step sequencer: walks every slice through theta/rho/pi/chi/iota for
// each round, with write-back strobes trailing reads by PIPE_LAT unstalled cycles.
module keccak_perm_ctrl #(
    parameter int NUM_ROUNDS = 24,
    parameter int NUM_SLICES = 64,
    parameter int ADDR_W     = 6,
    parameter int RND_W      = 5,
    parameter int PIPE_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    keccak_perm_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_NEXT, S_DONE} state_t;

    localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [2:0]        STEP_IOTA  = 3'd4;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_SLICES - 1);
    localparam logic [RND_W-1:0]  LAST_RND   = RND_W'(NUM_ROUNDS - 1);
    localparam logic [CNT_W-1:0]  LAST_DRAIN = CNT_W'(PIPE_LAT - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [RND_W-1:0]  round_reg, round_next;
    logic [2:0]        step_reg, step_next;
    logic [CNT_W-1:0]  drain_reg, drain_next;
    logic              stall_active;
    logic              advance;
    logic              rd_en;

    // stall only has meaning while slices are in flight
    assign stall_active = bus.stall && (state_reg == S_RUN || state_reg == S_DRAIN);
    assign advance      = !stall_active;
    assign rd_en        = (state_reg == S_RUN) && !bus.stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            round_reg <= '0;
            step_reg  <= '0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            round_reg <= round_next;
            step_reg  <= step_next;
            drain_reg <= drain_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        round_next = round_reg;
        step_next  = step_reg;
        drain_next = drain_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_RUN;
                    addr_next  = '0;
                    round_next = '0;
                    step_next  = '0;
                end
            end
            S_RUN: begin
                if (!bus.stall) begin
                    if (addr_reg == LAST_ADDR) begin
                        state_next = S_DRAIN;
                        addr_next  = '0;
                        drain_next = '0;
                    end else begin
                        addr_next = addr_reg + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!bus.stall) begin
                    if (drain_reg == LAST_DRAIN) begin
                        state_next = S_NEXT;
                        drain_next = '0;
                    end else begin
                        drain_next = drain_reg + CNT_W'(1);
                    end
                end
            end
            S_NEXT: begin
                if (step_reg != STEP_IOTA) begin
                    state_next = S_RUN;
                    step_next  = step_reg + 3'd1;
                end else if (round_reg != LAST_RND) begin
                    state_next = S_RUN;
                    step_next  = '0;
                    round_next = round_reg + RND_W'(1);
                end else begin
                    state_next = S_DONE;
                    step_next  = '0;
                    round_next = '0;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Write-back delay line; idle slots carry address 0 so wr_addr rests at 0.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_pipe
            logic              we_in;
            logic [ADDR_W-1:0] wa_in;
            logic              we_reg;
            logic [ADDR_W-1:0] wa_reg;

            if (gi == 0) begin : g_first
                assign we_in = rd_en;
                assign wa_in = rd_en ? addr_reg : '0;
            end else begin : g_rest
                assign we_in = g_pipe[gi-1].we_reg;
                assign wa_in = g_pipe[gi-1].wa_reg;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    we_reg <= 1'b0;
                    wa_reg <= '0;
                end else if (advance) begin
                    we_reg <= we_in;
                    wa_reg <= wa_in;
                end
            end
        end
    endgenerate

    assign bus.busy      = (state_reg == S_RUN) || (state_reg == S_DRAIN) || (state_reg == S_NEXT);
    assign bus.done      = (state_reg == S_DONE);
    assign bus.round_idx = round_reg;
    assign bus.step_sel  = step_reg;
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = addr_reg;
    assign bus.wr_en     = g_pipe[PIPE_LAT-1].we_reg && advance;
    assign bus.wr_addr   = g_pipe[PIPE_LAT-1].wa_reg;
endmodule

// File: tb/tb_keccak_perm_ctrl.sv
// Directed bench: small 2-round/4-slice instance checked against a vector table
// and corner-case sequences, plus a default-size instance for full latency.
module tb_keccak_perm_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keccak_perm_ctrl_if #(.ADDR_W(2), .RND_W(1)) bus_s ();
    keccak_perm_ctrl_if #(.ADDR_W(6), .RND_W(5)) bus_d ();

    keccak_perm_ctrl #(
        .NUM_ROUNDS(2), .NUM_SLICES(4), .ADDR_W(2), .RND_W(1), .PIPE_LAT(1)
    ) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s.slave)
    );

    keccak_perm_ctrl dut_d (
        .clk(clk), .rst(rst), .bus(bus_d.slave)
    );

    typedef struct {
        int          scen;
        int          cyc;
        logic [11:0] exp;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];
    int nchecks = 0;
    int nerr    = 0;

    function automatic logic [11:0] mk(input int busy, input int done, input int step, input int rnd,
                                       input int rde, input int ra, input int wre, input int wa);
        return {busy[0], done[0], step[2:0], rnd[0], rde[0], ra[1:0], wre[0], wa[1:0]};
    endfunction

    function automatic logic [11:0] pack_s();
        return {bus_s.busy, bus_s.done, bus_s.step_sel, bus_s.round_idx,
                bus_s.rd_en, bus_s.rd_addr, bus_s.wr_en, bus_s.wr_addr};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_pulse_s(input bit hold);
        @(negedge clk);
        bus_s.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus_s.start = 1'b0;
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1;
        bus_s.start = 1'b0;
        bus_s.stall = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One permutation on the small instance; cycle c is observed after c posedges past start
    task automatic run_perm(input int scen, input int stall_from, input int stall_to,
                            input int done_cyc, input int last_cyc, input bit hold);
        int wcount;
        int exp_wa;
        wcount = 0;
        exp_wa = 0;
        start_pulse_s(hold);
        for (int c = 1; c <= last_cyc; c++) begin
            @(negedge clk);
            bus_s.stall = (c >= stall_from && c <= stall_to);
            #1;
            chk($sformatf("done s%0d c%0d", scen, c), int'(bus_s.done), (c == done_cyc) ? 1 : 0);
            if (bus_s.wr_en) begin
                wcount++;
                chk($sformatf("wr_order s%0d c%0d", scen, c), int'(bus_s.wr_addr), exp_wa);
                exp_wa = (exp_wa + 1) % 4;
            end
            for (int v = 0; v < NVEC; v++) begin
                if (vecs[v].scen == scen && vecs[v].cyc == c)
                    chk($sformatf("vec s%0d c%0d", scen, c), int'(pack_s()), int'(vecs[v].exp));
            end
        end
        bus_s.stall = 1'b0;
        bus_s.start = 1'b0;
        chk($sformatf("writes s%0d", scen), wcount, 40);
    endtask

    initial begin
        int done_at, writes, iota_cnt, max_rnd, prev_step;

        // scenario 0: plain run
        vecs[0]  = '{0, 1,  mk(1,0,0,0,1,0,0,0)};
        vecs[1]  = '{0, 2,  mk(1,0,0,0,1,1,1,0)};
        vecs[2]  = '{0, 3,  mk(1,0,0,0,1,2,1,1)};
        vecs[3]  = '{0, 4,  mk(1,0,0,0,1,3,1,2)};
        vecs[4]  = '{0, 5,  mk(1,0,0,0,0,0,1,3)};
        vecs[5]  = '{0, 6,  mk(1,0,0,0,0,0,0,0)};
        vecs[6]  = '{0, 7,  mk(1,0,1,0,1,0,0,0)};
        vecs[7]  = '{0, 30, mk(1,0,4,0,0,0,0,0)};
        vecs[8]  = '{0, 31, mk(1,0,0,1,1,0,0,0)};
        vecs[9]  = '{0, 60, mk(1,0,4,1,0,0,0,0)};
        vecs[10] = '{0, 61, mk(0,1,0,0,0,0,0,0)};
        vecs[11] = '{0, 62, mk(0,0,0,0,0,0,0,0)};
        // scenario 1: stall cycles 3..5 while rd_addr=2
        vecs[12] = '{1, 3,  mk(1,0,0,0,0,2,0,1)};
        vecs[13] = '{1, 4,  mk(1,0,0,0,0,2,0,1)};
        vecs[14] = '{1, 5,  mk(1,0,0,0,0,2,0,1)};
        vecs[15] = '{1, 6,  mk(1,0,0,0,1,2,1,1)};
        vecs[16] = '{1, 7,  mk(1,0,0,0,1,3,1,2)};
        vecs[17] = '{1, 8,  mk(1,0,0,0,0,0,1,3)};
        vecs[18] = '{1, 9,  mk(1,0,0,0,0,0,0,0)};
        vecs[19] = '{1, 10, mk(1,0,1,0,1,0,0,0)};
        // scenario 2: start held high throughout
        vecs[20] = '{2, 61, mk(0,1,0,0,0,0,0,0)};
        vecs[21] = '{2, 62, mk(0,0,0,0,0,0,0,0)};
        vecs[22] = '{2, 63, mk(1,0,0,0,1,0,0,0)};

        bus_s.start = 1'b0;
        bus_s.stall = 1'b0;
        bus_d.start = 1'b0;
        bus_d.stall = 1'b0;

        // reset and idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_default_inst", int'({bus_d.busy, bus_d.done, bus_d.rd_en, bus_d.wr_en,
                                         bus_d.rd_addr, bus_d.wr_addr, bus_d.round_idx, bus_d.step_sel}), 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("idle c%0d", c), int'(pack_s()), 0);
        end

        run_perm(0, -1, -1, 61, 62, 1'b0);
        reset_all();
        run_perm(1, 3, 5, 64, 65, 1'b0);
        reset_all();
        run_perm(2, -1, -1, 61, 63, 1'b1);
        reset_all();

        // abort mid-run during round 0, CHI
        start_pulse_s(1'b0);
        for (int c = 1; c <= 20; c++) @(negedge clk);
        #1;
        chk("abort_step_chi", int'(bus_s.step_sel), 3);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_outputs", int'(pack_s()), 0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("abort_quiet c%0d", c), int'(pack_s()), 0);
        end
        start_pulse_s(1'b0);
        @(negedge clk);
        #1;
        chk("restart_first", int'(pack_s()), int'(mk(1,0,0,0,1,0,0,0)));
        reset_all();

        // default-size permutation
        @(negedge clk);
        bus_d.start = 1'b1;
        @(posedge clk);
        #1;
        bus_d.start = 1'b0;
        done_at = 0;
        writes = 0;
        iota_cnt = 0;
        max_rnd = 0;
        prev_step = 0;
        for (int c = 1; c <= 9000 && done_at == 0; c++) begin
            @(negedge clk);
            #1;
            if (bus_d.wr_en) writes++;
            if (int'(bus_d.step_sel) == 4 && prev_step != 4) iota_cnt++;
            prev_step = int'(bus_d.step_sel);
            if (int'(bus_d.round_idx) > max_rnd) max_rnd = int'(bus_d.round_idx);
            if (bus_d.done) done_at = c;
        end
        chk("full_done_cycle", done_at, 7921);
        chk("full_writes", writes, 7680);
        chk("full_iota_steps", iota_cnt, 24);
        chk("full_max_round", max_rnd, 23);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule
